// File: rtl/uart_apb_ctrl.sv
// APB master that configures a uart16550 slave, then streams bytes into its THR after polling LSR.THRE.
// Defining UART_APB_CTRL_RX_EN adds an LSR.DR poll and a RBR read feeding a valid/ready receive port.
module uart_apb_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VAL   = 8'h03,
    parameter logic [7:0]  FCR_VAL   = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [31:0] m_paddr,
    output logic [31:0] m_pwdata,
    output logic [3:0]  m_pstrb,
    output logic [2:0]  m_pprot,
    input  logic        m_pready,
    input  logic [31:0] m_prdata,
    input  logic        m_pslverr,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        init_done,
    output logic        err,
`ifdef UART_APB_CTRL_RX_EN
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
`endif
    output logic        busy
);

    localparam logic [2:0] REG_THR = 3'd0;
    localparam logic [2:0] REG_DLL = 3'd0;
    localparam logic [2:0] REG_DLM = 3'd1;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_FCR = 3'd2;
    localparam logic [2:0] REG_LCR = 3'd3;
    localparam logic [2:0] REG_LSR = 3'd5;

    typedef enum logic [3:0] {
        S_CFG0, S_CFG1, S_CFG2, S_CFG3, S_CFG4, S_CFG5,
        S_IDLE, S_POLL, S_SEND
`ifdef UART_APB_CTRL_RX_EN
        , S_RX_POLL, S_RX_READ
`endif
    } state_t;

    // PH_OFF means no transfer on the bus; it is also the post-reset phase of CFG0.
    typedef enum logic [1:0] {PH_OFF, PH_SETUP, PH_ACCESS} phase_t;

    state_t      r_state, w_state_nxt;
    phase_t      r_phase, w_phase_nxt;
    logic [7:0]  r_hold;
    logic        r_init_done;
    logic        r_err;

    logic [2:0]  w_reg;
    logic        w_write;
    logic [7:0]  w_wbyte;
    logic [31:0] w_addr;
    logic [1:0]  w_lane;
    logic        w_done;
    logic        w_thre;

`ifdef UART_APB_CTRL_RX_EN
    logic        r_rx_valid;
    logic [7:0]  r_rx_data;
    logic        w_dr;
    logic [7:0]  w_rx_byte;
`endif

    // Register and payload of the transfer belonging to the current state.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_reg   = REG_THR;
        w_write = 1'b0;
        w_wbyte = 8'h00;
        case (r_state)
            S_CFG0:    begin w_reg = REG_LCR; w_write = 1'b1; w_wbyte = LCR_VAL | 8'h80; end
            S_CFG1:    begin w_reg = REG_DLL; w_write = 1'b1; w_wbyte = DIVISOR[7:0];    end
            S_CFG2:    begin w_reg = REG_DLM; w_write = 1'b1; w_wbyte = DIVISOR[15:8];   end
            S_CFG3:    begin w_reg = REG_LCR; w_write = 1'b1; w_wbyte = LCR_VAL;         end
            S_CFG4:    begin w_reg = REG_FCR; w_write = 1'b1; w_wbyte = FCR_VAL;         end
            S_CFG5:    begin w_reg = REG_IER; w_write = 1'b1; w_wbyte = 8'h00;           end
            S_POLL:    w_reg = REG_LSR;
            S_SEND:    begin w_reg = REG_THR; w_write = 1'b1; w_wbyte = r_hold;          end
`ifdef UART_APB_CTRL_RX_EN
            S_RX_POLL: w_reg = REG_LSR;
            S_RX_READ: w_reg = REG_THR;
`endif
            default:   ;
        endcase
    end

    assign w_addr = BASE_ADDR + 32'(w_reg);
    assign w_lane = w_addr[1:0];
    assign w_done = (r_phase == PH_ACCESS) && m_pready;
    assign w_thre = m_prdata[{w_lane, 3'd5}];
`ifdef UART_APB_CTRL_RX_EN
    assign w_dr      = m_prdata[{w_lane, 3'd0}];
    assign w_rx_byte = m_prdata[{w_lane, 3'd0} +: 8];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (r_phase == PH_SETUP) begin
            w_phase_nxt = PH_ACCESS;
        end else if (r_phase == PH_OFF && r_state != S_IDLE) begin
            w_phase_nxt = PH_SETUP;
        end

        if (r_state == S_IDLE) begin
            if (tx_valid) begin
                w_state_nxt = S_POLL;
                w_phase_nxt = PH_SETUP;
            end
`ifdef UART_APB_CTRL_RX_EN
            else if (!r_rx_valid) begin
                w_state_nxt = S_RX_POLL;
                w_phase_nxt = PH_SETUP;
            end
`endif
        end else if (w_done) begin
            // Back-to-back by default; states that return to IDLE drop the bus below.
            w_phase_nxt = PH_SETUP;
            case (r_state)
                S_CFG0:    w_state_nxt = S_CFG1;
                S_CFG1:    w_state_nxt = S_CFG2;
                S_CFG2:    w_state_nxt = S_CFG3;
                S_CFG3:    w_state_nxt = S_CFG4;
                S_CFG4:    w_state_nxt = S_CFG5;
                S_POLL:    if (w_thre && !m_pslverr) w_state_nxt = S_SEND;
`ifdef UART_APB_CTRL_RX_EN
                S_RX_POLL: begin
                    if (w_dr && !m_pslverr) begin
                        w_state_nxt = S_RX_READ;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_phase_nxt = PH_OFF;
                    end
                end
`endif
                default: begin
                    w_state_nxt = S_IDLE;
                    w_phase_nxt = PH_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: synchronous reset, and non-blocking assignments for all state so every flop samples pre-edge values.
        if (reset) begin
            r_state     <= S_CFG0;
            r_phase     <= PH_OFF;
            r_hold      <= 8'h00;
            r_init_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            if (r_state == S_IDLE && tx_valid) r_hold <= tx_data;
            if (w_done && r_state == S_CFG5) r_init_done <= 1'b1;
            if (w_done && m_pslverr) r_err <= 1'b1;
        end
    end

`ifdef UART_APB_CTRL_RX_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else if (w_done && r_state == S_RX_READ) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= w_rx_byte;
        end else if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
`endif

    assign m_psel    = (r_phase != PH_OFF);
    assign m_penable = (r_phase == PH_ACCESS);
    assign m_pwrite  = m_psel && w_write;
    assign m_paddr   = m_psel ? w_addr : BASE_ADDR;
    assign m_pwdata  = m_pwrite ? (32'(w_wbyte) << {w_lane, 3'b000}) : 32'h0;
    assign m_pstrb   = m_pwrite ? (4'b0001 << w_lane) : 4'b0000;
    assign m_pprot   = 3'b000;
    assign tx_ready  = (r_state == S_IDLE);
    assign init_done = r_init_done;
    assign err       = r_err;
    assign busy      = m_psel;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Scoreboard bench for uart_apb_ctrl: a UART-side APB slave model answers LSR reads from a script,
// a monitor pops expected transfers on every completed access.
module tb_uart_apb_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [15:0] DIV  = 16'd27;
    localparam logic [7:0]  LCR  = 8'h03;
    localparam logic [7:0]  FCR  = 8'h07;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [3:0]  m_pstrb;
    logic [2:0]  m_pprot;
    logic        m_pready = 1'b0;
    logic [31:0] m_prdata = 32'h0;
    logic        m_pslverr = 1'b0;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        init_done, err, busy;

    uart_apb_ctrl #(
        .BASE_ADDR(BASE), .DIVISOR(DIV), .LCR_VAL(LCR), .FCR_VAL(FCR)
    ) dut (
        .clock(clk), .reset(reset),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_pprot(m_pprot),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .init_done(init_done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } xfer_t;

    xfer_t      sb_q[$];
    logic [7:0] lsr_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_idx = 0;
    int stall_idx = -1;
    int stall_n = 0;
    int err_idx = -1;
    int stall_left = 0;
    xfer_t setup_snap;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic xfer_t wr_x(input logic [2:0] r, input logic [7:0] b);
        xfer_t x;
        x.wr   = 1'b1;
        x.addr = BASE + 32'(r);
        x.data = 32'(b) << (8 * int'(x.addr[1:0]));
        x.strb = 4'b0001 << x.addr[1:0];
        return x;
    endfunction

    function automatic xfer_t rd_x(input logic [2:0] r);
        xfer_t x;
        x.wr   = 1'b0;
        x.addr = BASE + 32'(r);
        x.data = 32'h0;
        x.strb = 4'b0000;
        return x;
    endfunction

    // Slave model plus monitor, evaluated on the falling edge away from the DUT's active edge.
    always @(negedge clk) begin
        xfer_t act;
        xfer_t exp;
        logic [7:0] lsr;
        int sh;
        if (reset) begin
            xfer_idx   = 0;
            stall_left = 0;
            m_pready   = 1'b0;
            m_pslverr  = 1'b0;
        end else if (m_psel && !m_penable) begin
            setup_snap = '{m_pwrite, m_paddr, m_pwdata, m_pstrb};
            stall_left = (xfer_idx == stall_idx) ? stall_n : 0;
            m_pready   = 1'b0;
            m_pslverr  = 1'b0;
        end else if (m_psel && m_penable) begin
            check("access_stable", xfer_t'({m_pwrite, m_paddr, m_pwdata, m_pstrb}), setup_snap);
            if (stall_left > 0) begin
                stall_left--;
                m_pready = 1'b0;
            end else begin
                m_pready  = 1'b1;
                m_pslverr = (xfer_idx == err_idx);
                sh = 8 * int'(m_paddr[1:0]);
                m_prdata = $urandom;
                if (!m_pwrite && m_paddr == BASE + 32'd5) begin
                    lsr = (lsr_q.size() > 0) ? lsr_q.pop_front() : 8'h20;
                    m_prdata = (m_prdata & ~(32'hFF << sh)) | (32'(lsr) << sh);
                end
                act = '{m_pwrite, m_paddr, (m_pwrite ? m_pwdata : 32'h0), m_pstrb};
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got %0h expected none", act);
                end else begin
                    exp = sb_q.pop_front();
                    check($sformatf("xfer%0d", xfer_idx), {act, m_pprot}, {exp, 3'b000});
                end
                xfer_idx++;
            end
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
        end
    end

    task automatic push_config();
        sb_q.push_back(wr_x(3'd3, LCR | 8'h80));
        sb_q.push_back(wr_x(3'd0, DIV[7:0]));
        sb_q.push_back(wr_x(3'd1, DIV[15:8]));
        sb_q.push_back(wr_x(3'd3, LCR));
        sb_q.push_back(wr_x(3'd2, FCR));
        sb_q.push_back(wr_x(3'd1, 8'h00));
    endtask

    task automatic reset_phase(input int s_idx, input int s_n, input int e_idx, input int exp_lat);
        int rel;
        int n;
        @(negedge clk);
        #1;
        reset = 1'b1;
        tx_valid = 1'b0;
        stall_idx = s_idx;
        stall_n = s_n;
        err_idx = e_idx;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {m_psel, m_penable, m_pwrite, m_pstrb, m_pwdata, m_paddr, m_pprot, tx_ready, init_done, err, busy},
              {1'b0, 1'b0, 1'b0, 4'h0, 32'h0, BASE, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
        #1;
        sb_q.delete();
        lsr_q.delete();
        push_config();
        reset = 1'b0;
        rel = cyc + 1;
        n = 0;
        while (!init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("init_latency", 128'(cyc - rel), 128'(exp_lat));
    endtask

    // Queue the reads/write the byte should cause, then hand it over and time tx_ready's return.
    task automatic send_byte(input logic [7:0] b, input int k, input logic [7:0] ready_val, input bit rnd);
        int n;
        int cn;
        for (int i = 0; i < k; i++) begin
            lsr_q.push_back(rnd ? (8'($urandom) & 8'hDF) : 8'h00);
            sb_q.push_back(rd_x(3'd5));
        end
        lsr_q.push_back(ready_val | 8'h20);
        sb_q.push_back(rd_x(3'd5));
        sb_q.push_back(wr_x(3'd0, b));
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", tx_ready, 1'b1);
        #1;
        tx_valid = 1'b1;
        tx_data = b;
        cn = cyc;
        @(negedge clk);
        check("tx_ready_drop", tx_ready, 1'b0);
        #1;
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_latency", 128'(cyc - cn), 128'(5 + 2 * k));
    endtask

    initial begin
        int n;
        bit seen;
        tx_valid = 1'b0;
        tx_data = 8'h00;

        reset_phase(-1, 0, -1, 12);
        check("err_clear", err, 1'b0);
        send_byte(8'h41, 0, 8'h60, 1'b0);
        send_byte(8'h5A, 3, 8'h20, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'($urandom), $urandom_range(0, 3), 8'($urandom), 1'b1);
        end

        // DLL access stretched by three wait states.
        reset_phase(1, 3, -1, 15);
        send_byte(8'hC3, 1, 8'h20, 1'b1);

        // Slave error on the FCR write.
        reset_phase(-1, 0, 4, 12);
        check("err_set", err, 1'b1);
        send_byte(8'h7E, 2, 8'h20, 1'b1);
        check("err_sticky", err, 1'b1);

        // Reset while the THR write is held in ACCESS.
        reset_phase(7, 20, -1, 12);
        sb_q.push_back(rd_x(3'd5));
        sb_q.push_back(wr_x(3'd0, 8'h99));
        lsr_q.push_back(8'h20);
        @(negedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data = 8'h99;
        @(negedge clk);
        #1;
        tx_valid = 1'b0;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
            @(negedge clk);
            seen = m_psel && m_penable && m_pwrite && (m_paddr == BASE);
            n++;
        end
        check("thr_access_seen", seen, 1'b1);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abandon_bus", {m_psel, m_penable, busy, tx_ready}, 4'b0000);
        reset_phase(-1, 0, -1, 12);
        send_byte(8'h24, 0, 8'h20, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", 128'(sb_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_apb_ctrl.md
Name: uart_apb_ctrl

Overview:
- APB master that sequences the uart16550 APB slave.
- After reset it programs the line, divisor and FIFO registers, then transmits bytes from a valid/ready stream.
- Before each transmit write it polls LSR.THRE (LSR bit 5).
- Sits between an on-chip byte producer (boot ROM printer or debug stream) and the UART APB port; it is the only master on that port.

Parameters:
- BASE_ADDR, 32'h0000_0000, UART base byte address; register n is at BASE_ADDR+n.
- DIVISOR, 16'd27, baud divisor; low byte written to DLL, high byte to DLM.
- LCR_VAL, 8'h03, line control value (8N1); bit 7 must be 0.
- FCR_VAL, 8'h07, FIFO control value (enable FIFOs, clear both FIFOs).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_psel  out  1  APB select
- m_penable  out  1  APB enable
- m_pwrite  out  1  APB write
- m_paddr  out  32  APB byte address
- m_pwdata  out  32  write data; byte placed in lane paddr[1:0]
- m_pstrb  out  4  one-hot lane strobe for writes; 0 for reads
- m_pprot  out  3  constant 3'b000
- m_pready  in  1  APB ready
- m_prdata  in  32  APB read data
- m_pslverr  in  1  APB error
- tx_valid  in  1  byte offered
- tx_ready  out  1  byte accepted when tx_valid & tx_ready
- tx_data  in  8  byte to transmit
- init_done  out  1  configuration sequence complete
- err  out  1  sticky; set on any pslverr
- busy  out  1  APB transfer in progress (= m_psel)

Behaviour:
- Reset is synchronous and active-high on clock, and takes effect in any state.
  - State goes to CFG0; every output is 0; m_paddr = BASE_ADDR.
  - A transfer in progress is abandoned: psel drops at the next edge while reset is high.
- APB protocol:
  - SETUP cycle: psel=1, penable=0.
  - ACCESS cycle(s): psel=1, penable=1, held until pready=1.
  - paddr, pwrite, pwdata and pstrb are stable from SETUP through the completing ACCESS.
  - No idle cycle between back-to-back transfers. Each transfer takes at least 2 cycles.
- Read data: the byte is taken from lane paddr[1:0] of m_prdata on the completing ACCESS cycle.
- Configuration states. Each state performs one APB write, then advances:
  - CFG0: LCR(3) <= LCR_VAL|8'h80
  - CFG1: DLL(0) <= DIVISOR[7:0]
  - CFG2: DLM(1) <= DIVISOR[15:8]
  - CFG3: LCR(3) <= LCR_VAL
  - CFG4: FCR(2) <= FCR_VAL
  - CFG5: IER(1) <= 8'h00
- CFG0 SETUP occurs in the first cycle after reset deasserts. With zero-wait pready, init_done rises 12 cycles later and stays high until reset.
- IDLE: tx_ready=1 and init_done=1. On handshake, tx_data is latched into a holding register; go to POLL.
- POLL: APB read of LSR(5).
  - If bit 5 = 1: go to SEND.
  - Else: repeat POLL immediately. There is no timeout.
- SEND: APB write of THR(0) with the held byte; then go to IDLE.
- tx_ready is 0 in every state other than IDLE. It is never combinationally dependent on tx_valid.
- Zero-wait throughput:
  - Handshake at cycle N.
  - LSR SETUP at N+1, ACCESS at N+2.
  - THR SETUP at N+3, ACCESS at N+4.
  - tx_ready=1 at N+5.
- pready wait states stretch ACCESS cycles only; the state order is unchanged.
- pslverr:
  - Sampled on the completing ACCESS cycle; sets err.
  - The sequence continues as if the transfer succeeded.
  - A POLL read that completes with pslverr is treated as THRE=0.

Optional Feature:
- Macro: UART_APB_CTRL_RX_EN.
- When defined, the block adds these ports:
  - rx_valid  out  1
  - rx_ready  in  1
  - rx_data  out  8
- RX_POLL is entered from IDLE when tx_valid=0 and no rx byte is pending.
  - It performs an APB read of LSR.
  - If bit 0 = 1, it then reads RBR(0) into rx_data and asserts rx_valid.
  - Otherwise it returns to IDLE.
- rx_valid holds, with rx_data stable, until rx_valid & rx_ready. No further RX poll occurs while it is pending.
- TX has priority when leaving IDLE. tx_ready=0 during RX states.
- When the macro is not defined, these ports are absent and no RX reads are ever issued.

Test Plan:
- Reset, then idle with pready tied to psel&penable:
  - Writes appear in order to addr 3/0/1/3/2/1 with data 83/1B/00/03/07/00.
  - pstrb is 1000/0001/0010/1000/0100/0010.
  - init_done=1 12 cycles after reset release.
- tx byte 8'h41, LSR returns 8'h60:
  - One LSR read at addr 5, then a THR write with pwdata[7:0]=41 and pstrb=0001.
  - tx_ready returns 5 cycles after the handshake.
- LSR returns 8'h00 three times, then 8'h20: exactly 4 LSR reads precede the single THR write.
- pready held low 3 cycles during the DLL write:
  - psel, penable, paddr and pwdata stay stable.
  - The sequence resumes with DLM; init_done is delayed 3 cycles.
- pslverr=1 on the FCR write: err=1 and stays 1; init_done still asserts; reset clears err.
- Reset asserted during the ACCESS phase of a THR write: psel=0 on the next cycle; the configuration sequence restarts at CFG0.
